ram: RTL and testbench



---
 rtl/ram.sv | 49 ++++
 tb/tb_ram.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ram.sv
// ram: single-port, byte-wide, 256-word read/write memory.
// Writes happen on the rising edge of clk while EN is high. Reads are
// combinational from direccion. A synchronous reset loads each word with
// its own address value, so reads are predictable before any write.
// Optional build macro RAM_OUT_REG_EN: registers dato_s (read-old-data,
// one cycle of read latency, cleared to 0 on a reset edge).
module ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] direccion,
    input  logic [DATA_W-1:0] Dato_E,
    input  logic              EN,
    output logic [DATA_W-1:0] dato_s
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: the reset image (word i holds i) has priority over a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
        end else if (EN) begin
            mem[direccion] <= Dato_E;
        end
    end

`ifdef RAM_OUT_REG_EN
    // Registered read: samples the contents before this edge's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            dato_s <= '0;
        end else begin
            dato_s <= mem[direccion];
        end
    end
`else
    // Combinational read: no bypass, so a same-address write shows after the edge.
    always_comb begin
        dato_s = mem[direccion];
    end
`endif

endmodule

// File: tb/tb_ram.sv
// tb_ram: scoreboard bench for ram. The driver computes the expected read
// value from an array model and queues it; a monitor on the falling edge
// pops and compares against dato_s.
module tb_ram;

    logic       clk;
    logic       rst;
    logic [7:0] direccion;
    logic [7:0] Dato_E;
    logic       EN;
    logic [7:0] dato_s;

    ram dut (
        .clk       (clk),
        .rst       (rst),
        .direccion (direccion),
        .Dato_E    (Dato_E),
        .EN        (EN),
        .dato_s    (dato_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain array of current contents.
    logic [7:0] model [256];
    bit         model_ok = 0;
    bit         reg_ok   = 0;
    logic [7:0] reg_val  = 8'h00;

    // Inputs currently applied to the DUT (take effect on the next edge).
    logic       cur_rst  = 1'b0;
    logic       cur_en   = 1'b0;
    logic [7:0] cur_addr = 8'h00;
    logic [7:0] cur_data = 8'h00;

    task automatic cyc(input logic r, input logic e, input logic [7:0] a,
                       input logic [7:0] d, input string tag);
        exp_t x;
        @(posedge clk);
        // Effect of the edge just taken on the model.
        if (cur_rst) begin
            reg_val = 8'h00;
            reg_ok  = 1;
        end else begin
            reg_val = model[cur_addr];
            reg_ok  = reg_ok || model_ok;
        end
        if (cur_rst) begin
            for (int i = 0; i < 256; i++) model[i] = 8'(i);
            model_ok = 1;
        end else if (cur_en && model_ok) begin
            model[cur_addr] = cur_data;
        end
        #1;
        rst = r; EN = e; direccion = a; Dato_E = d;
        cur_rst = r; cur_en = e; cur_addr = a; cur_data = d;
`ifdef RAM_OUT_REG_EN
        if (reg_ok) begin
            x.val = reg_val; x.tag = tag;
            sb.push_back(x);
        end
`else
        if (model_ok) begin
            x.val = model[a]; x.tag = tag;
            sb.push_back(x);
        end
`endif
    endtask

    // Monitor: compare the presented read data against the queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            checks++;
            if (dato_s !== x.val) begin
                errors++;
                $display("FAIL %s: dato_s=%0d expected=%0d at %0t", x.tag, dato_s, x.val, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; EN = 1'b0; direccion = 8'h00; Dato_E = 8'h00;

        // Reset then read.
        cyc(1, 0, 8'd0, 8'd0, "reset_pulse");
        cyc(0, 0, 8'd0, 8'd0, "rst_read0");
        cyc(0, 0, 8'd1, 8'd0, "rst_read1");
        cyc(0, 0, 8'd2, 8'd0, "rst_read2");
        cyc(0, 0, 8'd5, 8'd0, "rst_read5");
        cyc(0, 0, 8'd10, 8'd0, "rst_read10");

        // Write burst, one word per edge.
        cyc(0, 1, 8'd3, 8'd111, "wr3");
        cyc(0, 1, 8'd6, 8'd77, "wr6");
        cyc(0, 1, 8'd8, 8'd55, "wr8");
        cyc(0, 1, 8'd9, 8'd22, "wr9");
        cyc(0, 1, 8'd10, 8'd200, "wr10");

        // Read back plus untouched neighbours.
        cyc(0, 0, 8'd3, 8'd0, "rd3");
        cyc(0, 0, 8'd6, 8'd0, "rd6");
        cyc(0, 0, 8'd8, 8'd0, "rd8");
        cyc(0, 0, 8'd9, 8'd0, "rd9");
        cyc(0, 0, 8'd10, 8'd0, "rd10");
        cyc(0, 0, 8'd4, 8'd0, "rd4_neigh");
        cyc(0, 0, 8'd7, 8'd0, "rd7_neigh");

        // Read-during-write at the same address, then retention.
        cyc(0, 1, 8'd20, 8'd99, "rdw20_before");
        cyc(0, 0, 8'd20, 8'd0, "rdw20_after");
        cyc(0, 0, 8'd20, 8'd0, "rdw20_hold");

        // Repeated writes to one address: last value wins.
        cyc(0, 1, 8'd30, 8'd1, "rep30_a");
        cyc(0, 1, 8'd30, 8'd2, "rep30_b");
        cyc(0, 1, 8'd30, 8'd3, "rep30_c");
        cyc(0, 0, 8'd30, 8'd0, "rep30_last");

        // Reset priority over EN and mid-operation restore.
        cyc(1, 1, 8'd3, 8'd250, "rst_en_edge");
        cyc(0, 0, 8'd3, 8'd0, "rstpri3");
        cyc(0, 0, 8'd6, 8'd0, "rstrestore6");
        cyc(0, 0, 8'd20, 8'd0, "rstrestore20");
        cyc(0, 0, 8'd255, 8'd0, "rd255");
        cyc(0, 1, 8'd255, 8'd0, "wr255");
        cyc(0, 0, 8'd255, 8'd0, "rd255_after");

        // Randomized traffic, biased toward a small address pool for reuse.
        for (int n = 0; n < 400; n++) begin
            logic       r, e;
            logic [7:0] a, d;
            r = ($urandom_range(0, 59) == 0);
            e = $urandom_range(0, 1) == 1;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(0, 7));
            d = 8'($urandom_range(0, 255));
            cyc(r, e, a, d, "random");
        end
        cyc(0, 0, 8'd0, 8'd0, "final");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
